interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of interrupt sources.
REQ-002 The block SHALL have parameter VECTOR_ADDR, default 13'h004, meaning the interrupt vector PC value.
REQ-003 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 int_src  in  NUM_SRC  raw peripheral interrupt levels.
REQ-006 q_end  in  1  high in the Q4 cycle of every instruction (instruction boundary).
REQ-007 instr_retfie  in  1  high with q_end when RETFIE retires.
REQ-008 ie_wr_en  in  1  write strobe for the enable register.
REQ-009 ie_wr_data  in  NUM_SRC+1  bit NUM_SRC is GIE; the low bits are per-source enables.
REQ-010 flag_clr_en  in  1  strobe that clears the flags selected by flag_clr_mask.
REQ-011 flag_clr_mask  in  NUM_SRC  flag bits to clear.
REQ-012 int_flags  out  NUM_SRC  sticky pending flags.
REQ-013 ie_rd_data  out  NUM_SRC+1  current {GIE, enables}.
REQ-014 irq_flush  out  1  forces the decoder to discard the fetched instruction.
REQ-015 stack_push  out  1  pushes the current PC onto the hardware stack.
REQ-016 pc_vector_en  out  1  loads VECTOR_ADDR into the PC.
REQ-017 pc_vector  out  13  constant VECTOR_ADDR.
REQ-018 irq_active  out  1  high while an interrupt entry sequence is running.

Function
REQ-019 Each int_src bit SHALL be registered once; a 0->1 transition SHALL set the matching int_flags bit on the next edge.
REQ-020 A flag SHALL stay set until flag_clr_en clears it with its mask bit set; when set and clear coincide, set SHALL win.
REQ-021 ie_wr_en SHALL update GIE and the enables on the next edge; instr_retfie SHALL set GIE; when both occur together, ie_wr_data SHALL win.
REQ-022 pending SHALL be defined as GIE & |(int_flags & enables), evaluated from the registered values only.
REQ-023 FSM states SHALL be IDLE, WAIT and ENTRY; IDLE -> WAIT when pending is true.
REQ-024 WAIT -> ENTRY when q_end is high.
REQ-025 WAIT -> IDLE if pending drops before q_end.
REQ-026 On the WAIT -> ENTRY edge, GIE SHALL be cleared.
REQ-027 ENTRY SHALL last exactly 4 cycles, tracked by a 2-bit phase counter starting at 0.
REQ-028 In ENTRY phase 0, irq_flush SHALL be 1.
REQ-029 In ENTRY phase 3, stack_push and pc_vector_en SHALL both be 1 for one cycle; the FSM SHALL then return to IDLE.
REQ-030 irq_active SHALL be 1 exactly in the WAIT and ENTRY states.
REQ-031 Interrupt latency SHALL be: flag set -> first q_end at least 1 cycle later -> 4-cycle ENTRY.
REQ-032 Flags SHALL keep setting during ENTRY; because GIE is 0, no new entry SHALL start until GIE is set again.
REQ-033 ie_wr_en setting GIE in the same cycle as q_end SHALL take effect only at the next boundary.

Reset
REQ-034 rst SHALL force IDLE, phase 0, int_flags 0, GIE 0, enables 0, the int_src history 0, and all strobes 0.
REQ-035 rst asserted mid-ENTRY SHALL abort the sequence with no stack_push or pc_vector_en.

Structure
REQ-036 The FSM state encoding and the default VECTOR_ADDR SHALL live in the shared ISA/constants package, alongside the ALU op codes.
REQ-037 The block SHALL be a single module with no sub-modules; the edge detector is inline.

Verification
REQ-038 Enables 4'b0001, GIE=1, pulse int_src[0] -> flag[0]=1 one edge later; after the next q_end, irq_flush for 1 cycle, then stack_push and pc_vector_en together 3 cycles later with pc_vector=0x004; GIE reads 0.
REQ-039 GIE=0, int_src[2] rises -> int_flags=4'b0100; irq_active stays 0 for 20 cycles.
REQ-040 Same-cycle flag_clr_en with mask 4'b0001 and an int_src[0] rise -> int_flags[0]=1.
REQ-041 During ENTRY, int_src[1] rises -> flag[1] set and no second entry; instr_retfie with q_end -> GIE=1, and a new entry starts at the following q_end.
REQ-042 rst asserted at ENTRY phase 2 -> next cycle: all outputs 0, irq_active 0, and no stack_push observed.
REQ-043 ie_wr_en with data 5'b0_0000 in the same cycle as instr_retfie -> GIE=0.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared ISA constants: ALU op codes, interrupt FSM states and the
// default interrupt vector used by the PC load path.
package interrupt_controller_pkg;

    localparam logic [12:0] DEFAULT_VECTOR = 13'h004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ENTRY
    } irq_state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_COM,
        ALU_INC,
        ALU_DEC,
        ALU_RLF,
        ALU_RRF,
        ALU_SWAP,
        ALU_PASS
    } alu_op_t;

endpackage

// File: rtl/interrupt_controller.sv
// Interrupt controller: rising-edge flag capture, {GIE, enables} register
// and a 4-cycle entry sequencer aligned to instruction boundaries.
// Ports:
//   clk, rst                     clock, sync active-high reset
//   int_src                      raw interrupt levels
//   q_end, instr_retfie          instruction boundary / RETFIE retire
//   ie_wr_en, ie_wr_data         {GIE, enables} write
//   flag_clr_en, flag_clr_mask   pending flag clear
//   int_flags, ie_rd_data        sticky flags / current {GIE, enables}
//   irq_flush, stack_push        entry strobes to decoder and stack
//   pc_vector_en, pc_vector      PC vector load
//   irq_active                   high in WAIT and ENTRY
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SRC     = 4,
    parameter logic [12:0] VECTOR_ADDR = DEFAULT_VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic               q_end,
    input  logic               instr_retfie,
    input  logic               ie_wr_en,
    input  logic [NUM_SRC:0]   ie_wr_data,
    input  logic               flag_clr_en,
    input  logic [NUM_SRC-1:0] flag_clr_mask,
    output logic [NUM_SRC-1:0] int_flags,
    output logic [NUM_SRC:0]   ie_rd_data,
    output logic               irq_flush,
    output logic               stack_push,
    output logic               pc_vector_en,
    output logic [12:0]        pc_vector,
    output logic               irq_active
);

    irq_state_t         state;
    irq_state_t         state_nx;
    logic [1:0]         phase;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] flags;
    logic [NUM_SRC-1:0] enables;
    logic               gie;
    logic               pending;
    logic               entry_start;

    assign pending     = gie & |(flags & enables);
    assign entry_start = (state == ST_WAIT) & (state_nx == ST_ENTRY);

    assign int_flags  = flags;
    assign ie_rd_data = {gie, enables};
    assign pc_vector  = VECTOR_ADDR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= 2'd0;
            src_q   <= '0;
            flags   <= '0;
            gie     <= 1'b0;
            enables <= '0;
        end else begin
            state <= state_nx;
            // Phase wraps 3 -> 0 as ENTRY hands back to IDLE.
            phase <= (state == ST_ENTRY) ? phase + 2'd1 : 2'd0;
            src_q <= int_src;
            // A new edge overrides a same-cycle clear.
            flags <= (flags & ~({NUM_SRC{flag_clr_en}} & flag_clr_mask))
                   | (int_src & ~src_q);
            if (ie_wr_en) begin
                gie     <= ie_wr_data[NUM_SRC];
                enables <= ie_wr_data[NUM_SRC-1:0];
            end else if (instr_retfie) begin
                gie <= 1'b1;
            end
            // Entry masks further interrupts even against a racing write.
            if (entry_start) begin
                gie <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        irq_flush    = 1'b0;
        stack_push   = 1'b0;
        pc_vector_en = 1'b0;
        irq_active   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                irq_active = 1'b1;
                if (!pending) begin
                    state_nx = ST_IDLE;
                end else if (q_end) begin
                    state_nx = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                irq_active = 1'b1;
                irq_flush  = (phase == 2'd0);
                if (phase == 2'd3) begin
                    stack_push   = 1'b1;
                    pc_vector_en = 1'b1;
                    state_nx     = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
